// File: rtl/wave_osc.sv
// Phase-accumulator audio oscillator: one signed PCM sample per handshake, with a
// sine, square or sawtooth shaper selected at elaboration. Thin per-shape wrappers follow.
module wave_osc #(
  parameter int  width_p         = 16,
  parameter real sampling_freq_p = 44100.0,
  parameter real note_freq_p     = 440.0,
  parameter int  shape_p         = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);

  localparam real         INC_R = note_freq_p / sampling_freq_p * 4294967296.0;
  localparam int          INC_I = $rtoi(INC_R + 0.5);
  localparam logic [31:0] INC   = INC_I;

  // Quarter-wave magnitude, round-half-up (argument is in the first quadrant so
  // the value is never negative). Taylor series keeps this to plain real arithmetic.
  function automatic int sin_mag(input int q);
    real x, term, sum, amp;
    x    = 3.14159265358979323846 * q / 512.0;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      sum  = sum + term;
    end
    amp = (2.0 ** (width_p - 1)) - 1.0;
    return $rtoi(amp * sum + 0.5);
  endfunction

  logic [31:0]        phase_q;
  logic [31:0]        phase_d;
  logic               hs;
  logic [width_p-1:0] shape_d;
  logic [width_p-1:0] rst_val;

  assign hs      = valid_o & ready_i;
  assign phase_d = hs ? phase_q + INC : phase_q;

  // Shapers look at phase_d so the registered sample lines up with phase_q.
  generate
    if (shape_p == 0) begin : g_sine
      logic [width_p-2:0] qrom [257];
      logic [9:0]         k;
      logic [8:0]         qi;
      logic [width_p-1:0] mag;

      for (genvar g = 0; g <= 256; g++) begin : g_rom
        localparam int M = sin_mag(g);
        assign qrom[g] = (width_p-1)'(M);
      end

      // Second quadrant mirrors the first; second half-period is the negation.
      assign k       = phase_d[31:22];
      assign qi      = (k[8:0] > 9'd256) ? (9'd0 - k[8:0]) : k[8:0];
      assign mag     = {1'b0, qrom[qi]};
      assign shape_d = k[9] ? -mag : mag;
      assign rst_val = '0;
    end else if (shape_p == 1) begin : g_square
      localparam logic [width_p-1:0] POS_A = {1'b0, {(width_p-1){1'b1}}};
      localparam logic [width_p-1:0] NEG_A = {1'b1, {(width_p-2){1'b0}}, 1'b1};
      assign shape_d = phase_d[31] ? NEG_A : POS_A;
      assign rst_val = POS_A;
    end else begin : g_saw
      localparam logic [width_p-1:0] MIN_V = {1'b1, {(width_p-1){1'b0}}};
      assign shape_d = {~phase_d[31], phase_d[30 -: width_p-1]};
      assign rst_val = MIN_V;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= '0;
      valid_o <= 1'b0;
      data_o  <= rst_val;
    end else begin
      phase_q <= phase_d;
      valid_o <= 1'b1;
      data_o  <= shape_d;
    end
  end

endmodule

module sinusoid #(
  parameter int  width_p         = 16,
  parameter real sampling_freq_p = 44100.0,
  parameter real note_freq_p     = 440.0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);
  wave_osc #(.width_p(width_p), .sampling_freq_p(sampling_freq_p),
             .note_freq_p(note_freq_p), .shape_p(0)) u_osc (
    .clk_i(clk_i), .reset_i(reset_i), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o));
endmodule

module square_wave #(
  parameter int  width_p         = 16,
  parameter real sampling_freq_p = 44100.0,
  parameter real note_freq_p     = 440.0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);
  wave_osc #(.width_p(width_p), .sampling_freq_p(sampling_freq_p),
             .note_freq_p(note_freq_p), .shape_p(1)) u_osc (
    .clk_i(clk_i), .reset_i(reset_i), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o));
endmodule

module sawtooth_wave #(
  parameter int  width_p         = 16,
  parameter real sampling_freq_p = 44100.0,
  parameter real note_freq_p     = 440.0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);
  wave_osc #(.width_p(width_p), .sampling_freq_p(sampling_freq_p),
             .note_freq_p(note_freq_p), .shape_p(2)) u_osc (
    .clk_i(clk_i), .reset_i(reset_i), .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o));
endmodule

// File: tb/tb_wave_osc.sv
// Scoreboard bench for wave_osc: a bench-side phase model pushes the expected
// sample for every cycle, and each scenario task pops and checks it.
module tb_wave_osc;

  localparam logic [31:0] INC = 32'd42852281;
  localparam real         PI  = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic        v0, v1, v2, v3;
  logic [15:0] d0, d1, d2, d3;

  always #5 clk = ~clk;

  wave_osc #(.width_p(16), .sampling_freq_p(44100.0), .note_freq_p(440.0), .shape_p(0)) u_sin (
    .clk_i(clk), .reset_i(rst), .ready_i(rdy), .valid_o(v0), .data_o(d0));
  square_wave   u_sq  (.clk_i(clk), .reset_i(rst), .ready_i(rdy), .valid_o(v1), .data_o(d1));
  sawtooth_wave u_saw (.clk_i(clk), .reset_i(rst), .ready_i(rdy), .valid_o(v2), .data_o(d2));
  sinusoid      u_sinw(.clk_i(clk), .reset_i(rst), .ready_i(rdy), .valid_o(v3), .data_o(d3));

  typedef struct { logic v; int sn; int sq; int sw; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_ph;
  logic        m_v;
  int          hs_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int f_saw(input logic [31:0] p);
    return int'(p >> 16) - 32768;
  endfunction

  function automatic int f_sq(input logic [31:0] p);
    return p[31] ? -32767 : 32767;
  endfunction

  function automatic int f_sin(input logic [31:0] p);
    int  k;
    real a;
    k = int'(p[31:22]);
    a = 32767.0 * $sin(2.0 * PI * k / 1024.0);
    return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
  endfunction

  // Drive one cycle, advance the model at the edge and queue what the DUT should show.
  task automatic step(input logic r, input logic rs);
    exp_t x;
    @(negedge clk);
    rdy = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_ph = '0; m_v = 1'b0; hs_cnt = 0;
    end else begin
      if (m_v && r) begin m_ph = m_ph + INC; hs_cnt++; end
      m_v = 1'b1;
    end
    x.v = m_v; x.sn = f_sin(m_ph); x.sq = f_sq(m_ph); x.sw = f_saw(m_ph);
    sb.push_back(x);
    #1;
  endtask

  task automatic do_reset();
    repeat (3) begin step(1'b1, 1'b1); e = sb.pop_front(); end
  endtask

  task automatic test_reset();
    repeat (3) begin
      step(1'b1, 1'b1);
      e = sb.pop_front();
      n_chk++; if ({v0, v1, v2} !== 3'b000) begin n_fail++; $display("FAIL rst_valid: got %b exp 000", {v0, v1, v2}); end
      n_chk++; if (d0 !== 16'h0000) begin n_fail++; $display("FAIL rst_sine: got %h exp 0000", d0); end
      n_chk++; if (d1 !== 16'h7FFF) begin n_fail++; $display("FAIL rst_square: got %h exp 7fff", d1); end
      n_chk++; if (d2 !== 16'h8000) begin n_fail++; $display("FAIL rst_saw: got %h exp 8000", d2); end
    end
    step(1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++; if ({v0, v1, v2} !== {3{e.v}}) begin n_fail++; $display("FAIL rel_valid: got %b exp %b", {v0, v1, v2}, {3{e.v}}); end
    n_chk++; if (s16(d2) !== e.sw) begin n_fail++; $display("FAIL rel_saw: got %0d exp %0d", s16(d2), e.sw); end
  endtask

  task automatic test_saw_step();
    int prev;
    repeat (100) begin
      step(1'b0, 1'b0);
      e = sb.pop_front();
      n_chk++; if (s16(d2) !== -32768) begin n_fail++; $display("FAIL saw_hold: got %0d exp -32768", s16(d2)); end
    end
    step(1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++; if (s16(d2) !== -32115) begin n_fail++; $display("FAIL saw_first: got %0d exp -32115", s16(d2)); end
    prev = s16(d2);
    for (int i = 0; i < 200 && hs_cnt < 101; i++) begin
      step(1'b1, 1'b0);
      e = sb.pop_front();
      n_chk++; if (s16(d2) !== e.sw) begin n_fail++; $display("FAIL saw_ramp: hs %0d got %0d exp %0d", hs_cnt, s16(d2), e.sw); end
      if (hs_cnt == 101) begin
        n_chk++; if (!(prev > s16(d2))) begin n_fail++; $display("FAIL saw_wrap: before %0d after %0d", prev, s16(d2)); end
      end
      prev = s16(d2);
    end
    n_chk++; if (hs_cnt !== 101) begin n_fail++; $display("FAIL saw_hs_budget: got %0d exp 101", hs_cnt); end
  endtask

  task automatic test_square();
    int ex;
    do_reset();
    repeat (110) begin
      step(1'b1, 1'b0);
      e = sb.pop_front();
      ex = (hs_cnt >= 51 && hs_cnt < 101) ? -32767 : 32767;
      n_chk++; if (s16(d1) !== ex) begin n_fail++; $display("FAIL square: hs %0d got %0d exp %0d", hs_cnt, s16(d1), ex); end
    end
  endtask

  task automatic test_sine();
    int seen [1024];
    for (int k = 0; k < 1024; k++) seen[k] = -100000;
    do_reset();
    repeat (700) begin
      step(1'b1, 1'b0);
      e = sb.pop_front();
      n_chk++; if (s16(d0) !== e.sn) begin n_fail++; $display("FAIL sine: hs %0d got %0d exp %0d", hs_cnt, s16(d0), e.sn); end
      n_chk++; if (s16(d3) !== e.sn) begin n_fail++; $display("FAIL sine_wrap_mod: hs %0d got %0d exp %0d", hs_cnt, s16(d3), e.sn); end
      n_chk++; if (s16(d0) > 32767 || s16(d0) < -32767) begin n_fail++; $display("FAIL sine_range: got %0d exp |x|<=32767", s16(d0)); end
      if (hs_cnt == 25) begin
        n_chk++; if (s16(d0) !== 32766) begin n_fail++; $display("FAIL sine_k255: got %0d exp 32766", s16(d0)); end
      end
      seen[int'(m_ph[31:22])] = s16(d0);
    end
    for (int k = 0; k < 512; k++) begin
      if (seen[k] != -100000 && seen[k+512] != -100000) begin
        n_chk++; if (seen[k+512] !== -seen[k]) begin n_fail++; $display("FAIL sine_neg: k %0d got %0d exp %0d", k, seen[k+512], -seen[k]); end
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 100 && hs_cnt < 37; i++) begin step(1'b1, 1'b0); e = sb.pop_front(); end
    n_chk++; if (s16(d2) !== f_saw(32'd37 * INC)) begin n_fail++; $display("FAIL mid_pre: got %0d exp %0d", s16(d2), f_saw(32'd37 * INC)); end
    step(1'b1, 1'b1);
    e = sb.pop_front();
    n_chk++; if ({v0, v1, v2} !== 3'b000) begin n_fail++; $display("FAIL mid_valid: got %b exp 000", {v0, v1, v2}); end
    n_chk++; if ({d0, d1, d2} !== {16'h0000, 16'h7FFF, 16'h8000}) begin n_fail++; $display("FAIL mid_data: got %h %h %h exp 0000 7fff 8000", d0, d1, d2); end
    step(1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++; if (d2 !== 16'h8000 || v2 !== 1'b1) begin n_fail++; $display("FAIL mid_release: got %h v%b exp 8000 v1", d2, v2); end
    step(1'b1, 1'b0);
    e = sb.pop_front();
    n_chk++; if (s16(d2) !== -32115) begin n_fail++; $display("FAIL mid_first: got %0d exp -32115", s16(d2)); end
  endtask

  task automatic test_stall();
    logic [47:0] prev;
    logic        r;
    do_reset();
    prev = {d0, d1, d2};
    repeat (400) begin
      r = 1'($urandom_range(0, 1));
      step(r, 1'b0);
      e = sb.pop_front();
      if (!r) begin
        n_chk++; if ({d0, d1, d2} !== prev) begin n_fail++; $display("FAIL stall_hold: got %h exp %h", {d0, d1, d2}, prev); end
      end
      n_chk++; if (s16(d2) !== f_saw(32'(hs_cnt) * INC)) begin n_fail++; $display("FAIL stall_saw: n %0d got %0d exp %0d", hs_cnt, s16(d2), f_saw(32'(hs_cnt) * INC)); end
      n_chk++; if (s16(d0) !== e.sn || s16(d1) !== e.sq) begin n_fail++; $display("FAIL stall_seq: got %0d %0d exp %0d %0d", s16(d0), s16(d1), e.sn, e.sq); end
      prev = {d0, d1, d2};
    end
  endtask

  initial begin
    m_ph = '0; m_v = 1'b0; hs_cnt = 0;
    test_reset();
    test_saw_step();
    test_square();
    test_sine();
    test_midreset();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
